// File: rtl/ssd1306_spi_tx.sv
// SPI mode-3 byte transmitter for the SSD1306 OLED: one byte per trigger/ready
// handshake, MSB first, with CSn held low across a frame until the last byte.
module ssd1306_spi_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       spi_tx_trigger_in,
  input  logic [7:0] spi_data_in,
  input  logic       spi_last_byte_in,
  output logic       spi_ready_out,
  output logic       oled_sclk_out,
  output logic       oled_sdin_out,
  output logic       oled_csn_out
);

  localparam int PW = $clog2(CLK_DIV + 1);
  localparam logic [PW-1:0] PHASE_LOAD = PW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_LOW,
    S_HIGH,
    S_CS_HOLD,
    S_CS_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          last_q, last_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          ready_q, ready_d;
  logic          sclk_q, sclk_d;
  logic          sdin_q, sdin_d;
  logic          csn_q, csn_d;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    last_d    = last_q;
    phase_d   = phase_q;
    ready_d   = ready_q;
    sclk_d    = sclk_q;
    sdin_d    = sdin_q;
    csn_d     = csn_q;

    if (state_q == S_IDLE) begin
      if (spi_tx_trigger_in) begin
        shift_d   = spi_data_in;
        last_d    = spi_last_byte_in;
        bit_cnt_d = 3'd0;
        ready_d   = 1'b0;
        phase_d   = PHASE_LOAD;
        // Mid-frame bytes skip setup: the first data bit goes out right away.
        if (csn_q) begin
          csn_d   = 1'b0;
          state_d = S_CS_SETUP;
        end else begin
          sclk_d  = 1'b0;
          sdin_d  = spi_data_in[7];
          state_d = S_LOW;
        end
      end
    end else if (phase_q != '0) begin
      phase_d = phase_q - 1'b1;
    end else begin
      phase_d = PHASE_LOAD;
      case (state_q)
        S_CS_SETUP: begin
          sclk_d  = 1'b0;
          sdin_d  = shift_q[7];
          state_d = S_LOW;
        end
        S_LOW: begin
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end
        S_HIGH: begin
          if (bit_cnt_q != 3'd7) begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            sdin_d    = shift_q[6];
            sclk_d    = 1'b0;
            state_d   = S_LOW;
          end else if (last_q) begin
            state_d = S_CS_HOLD;
          end else begin
            phase_d = '0;
            ready_d = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_CS_HOLD: begin
          csn_d   = 1'b1;
          state_d = S_CS_GAP;
        end
        S_CS_GAP: begin
          phase_d = '0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          phase_d = '0;
          ready_d = 1'b1;
          sclk_d  = 1'b1;
          csn_d   = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      last_q    <= 1'b0;
      phase_q   <= '0;
      ready_q   <= 1'b1;
      sclk_q    <= 1'b1;
      sdin_q    <= 1'b0;
      csn_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      last_q    <= last_d;
      phase_q   <= phase_d;
      ready_q   <= ready_d;
      sclk_q    <= sclk_d;
      sdin_q    <= sdin_d;
      csn_q     <= csn_d;
    end
  end

  assign spi_ready_out = ready_q;
  assign oled_sclk_out = sclk_q;
  assign oled_sdin_out = sdin_q;
  assign oled_csn_out  = csn_q;

endmodule

// File: tb/tb_ssd1306_spi_tx.sv
// Bench for ssd1306_spi_tx: a CLK_DIV=2 and a CLK_DIV=1 instance, with SPI
// monitors decoding bytes on SCLK rising edges against a scoreboard queue.
module tb_ssd1306_spi_tx;

  typedef struct {
    logic [7:0] data;
    logic       last;
    bit         first;
    int         expLow;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  logic       trigA = 1'b0, lastA = 1'b0;
  logic [7:0] dataA = 8'h00;
  logic       readyA, sclkA, sdinA, csnA;
  logic       trigB = 1'b0, lastB = 1'b0;
  logic [7:0] dataB = 8'h00;
  logic       readyB, sclkB, sdinB, csnB;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] sbA[$];
  logic [7:0] sbB[$];
  int         riseA[$];
  int         riseB[$];
  int         monBitsA = 0, monBitsB = 0;
  logic [7:0] monShiftA = 8'h00, monShiftB = 8'h00;
  logic       prevSclkA = 1'b1, prevSclkB = 1'b1;
  int         acceptCyc = 0;

  vec_t vecs[6];

  ssd1306_spi_tx #(.CLK_DIV(2)) dutA (
    .clk_in(clk), .reset_in(rst), .spi_tx_trigger_in(trigA),
    .spi_data_in(dataA), .spi_last_byte_in(lastA), .spi_ready_out(readyA),
    .oled_sclk_out(sclkA), .oled_sdin_out(sdinA), .oled_csn_out(csnA)
  );

  ssd1306_spi_tx #(.CLK_DIV(1)) dutB (
    .clk_in(clk), .reset_in(rst), .spi_tx_trigger_in(trigB),
    .spi_data_in(dataB), .spi_last_byte_in(lastB), .spi_ready_out(readyB),
    .oled_sclk_out(sclkB), .oled_sdin_out(sdinB), .oled_csn_out(csnB)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  // Decode each byte from SDIN at SCLK rising edges while CSn is low.
  always @(negedge clk) begin
    if (csnA) monBitsA = 0;
    else if (sclkA && !prevSclkA) begin
      monShiftA = {monShiftA[6:0], sdinA};
      monBitsA++;
      riseA.push_back(cyc);
      if (monBitsA == 8) begin
        monBitsA = 0;
        if (sbA.size() == 0) checkOutput("A extra byte", 1, 0);
        else checkOutput("A byte", int'(monShiftA), int'(sbA.pop_front()));
      end
    end
    prevSclkA = sclkA;
  end

  always @(negedge clk) begin
    if (csnB) monBitsB = 0;
    else if (sclkB && !prevSclkB) begin
      monShiftB = {monShiftB[6:0], sdinB};
      monBitsB++;
      riseB.push_back(cyc);
      if (monBitsB == 8) begin
        monBitsB = 0;
        if (sbB.size() == 0) checkOutput("B extra byte", 1, 0);
        else checkOutput("B byte", int'(monShiftB), int'(sbB.pop_front()));
      end
    end
    prevSclkB = sclkB;
  end

  // Sends one byte on instance A as soon as it is ready and checks handshake timing.
  task automatic applyStimulus(input vec_t v);
    int n = 0;
    int s;
    s = v.first ? 2 : 0;
    while (!readyA && n < 200) begin @(negedge clk); n++; end
    if (!readyA) begin
      checkOutput("A ready timeout", 0, 1);
      return;
    end
    riseA.delete();
    trigA = 1'b1; dataA = v.data; lastA = v.last;
    sbA.push_back(v.data);
    acceptCyc = cyc + 1;
    @(posedge clk);
    #1;
    trigA = 1'b0; dataA = ~v.data; lastA = ~v.last;
    n = 0;
    @(negedge clk);
    if (v.first) checkOutput("A csn after accept", int'(csnA), 0);
    while (!readyA && n < 400) begin n++; @(negedge clk); end
    checkOutput("A ready low cycles", n, v.expLow);
    checkOutput("A rise count", riseA.size(), 8);
    if (riseA.size() == 8) begin
      checkOutput("A first rise offset", riseA[0] - acceptCyc, 2 + s);
      checkOutput("A last rise offset", riseA[7] - acceptCyc, 30 + s);
    end
  endtask

  initial begin
    vec_t vr;
    int n;
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 38};
    vecs[1] = '{8'hAE, 1'b0, 1'b1, 34};
    vecs[2] = '{8'h8D, 1'b1, 1'b0, 36};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 34};
    vecs[4] = '{8'h00, 1'b0, 1'b0, 32};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 36};

    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle outputs A", {readyA, sclkA, csnA, sdinA}, 4'b1110);
      checkOutput("idle outputs B", {readyB, sclkB, csnB, sdinB}, 4'b1110);
    end

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Trigger held high while busy, data changed after acceptance.
    @(negedge clk);
    trigA = 1'b1; dataA = 8'h96; lastA = 1'b1;
    sbA.push_back(8'h96);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 dataA = 8'($urandom);
    end
    trigA = 1'b0;
    n = 0;
    while (!readyA && n < 200) begin @(negedge clk); n++; end
    checkOutput("A ready after held trigger", int'(readyA), 1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (readyA) n++;
    end
    checkOutput("A no requeued byte", n, 10);

    // Asynchronous reset in the middle of bit 3.
    trigA = 1'b1; dataA = 8'h5A; lastA = 1'b0;
    @(posedge clk);
    #1 trigA = 1'b0;
    n = 0;
    while (monBitsA != 3 && n < 200) begin @(negedge clk); n++; end
    checkOutput("A reached bit 3", monBitsA, 3);
    #2 rst = 1'b1;
    #1;
    checkOutput("A async reset outputs", {readyA, sclkA, csnA, sdinA}, 4'b1110);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    vr = '{8'hC3, 1'b1, 1'b1, 38};
    applyStimulus(vr);

    // CLK_DIV=1 instance: SCLK at clk/2, all ones.
    @(negedge clk);
    riseB.delete();
    trigB = 1'b1; dataB = 8'hFF; lastB = 1'b1;
    sbB.push_back(8'hFF);
    acceptCyc = cyc + 1;
    @(posedge clk);
    #1 trigB = 1'b0; dataB = 8'h00;
    n = 0;
    @(negedge clk);
    while (!readyB && n < 200) begin n++; @(negedge clk); end
    checkOutput("B ready low cycles", n, 19);
    checkOutput("B rise count", riseB.size(), 8);
    if (riseB.size() == 8) begin
      checkOutput("B first rise offset", riseB[0] - acceptCyc, 2);
      checkOutput("B rise spacing", riseB[7] - riseB[0], 14);
    end

    repeat (5) @(negedge clk);
    checkOutput("A scoreboard drained", sbA.size(), 0);
    checkOutput("B scoreboard drained", sbB.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
